// File: rtl/sram_byte_bridge_pkg.sv
// Shared types and constants for the word-to-byte SRAM bridge.
package sram_byte_bridge_pkg;

  localparam int unsigned WaitCntW = 4;

  typedef enum logic [2:0] {
    StIdle,
    StSetupLo,
    StAccessLo,
    StSetupHi,
    StAccessHi,
    StAck
  } state_e;

endpackage

// File: rtl/sram_byte_bridge_if.sv
// Upstream 16-bit word bus between the load/store unit (master) and the bridge (slave).
interface sram_byte_bridge_if;

  logic [19:1] m_addr;
  logic [15:0] m_data_out;
  logic [15:0] m_data_in;
  logic        m_access;
  logic        m_ack;
  logic        m_wr_en;
  logic [1:0]  m_bytesel;

  modport master (
    output m_addr, m_data_out, m_access, m_wr_en, m_bytesel,
    input  m_data_in, m_ack
  );

  modport slave (
    input  m_addr, m_data_out, m_access, m_wr_en, m_bytesel,
    output m_data_in, m_ack
  );

endinterface

// File: rtl/sram_wait_counter.sv
// Wait-state down-counter: loads WAIT_STATES, decrements while enabled, flags zero.
module sram_wait_counter
  import sram_byte_bridge_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done
);

  logic [WaitCntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = WaitCntW'(WAIT_STATES);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/sram_byte_bridge.sv
// Splits 16-bit word accesses into low/high byte cycles on an 8-bit async SRAM.
module sram_byte_bridge
  import sram_byte_bridge_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_byte_bridge_if.slave    bus,
  output logic [19:0]          sram_addr,
  output logic [7:0]           sram_wdata,
  input  logic [7:0]           sram_rdata,
  output logic                 sram_data_oe,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);

  state_e      state_q, state_d;
  logic [19:1] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;

  logic in_setup, in_access, hi_lane, wait_done;

  assign in_setup  = (state_q == StSetupLo) || (state_q == StSetupHi);
  assign in_access = (state_q == StAccessLo) || (state_q == StAccessHi);
  assign hi_lane   = (state_q == StSetupHi) || (state_q == StAccessHi);

  sram_wait_counter #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .load  (in_setup),
    .dec   (in_access),
    .done  (wait_done)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.m_access) begin
          addr_d  = bus.m_addr;
          wr_d    = bus.m_wr_en;
          sel_d   = bus.m_bytesel;
          wdata_d = bus.m_data_out;
          // Unselected lanes of a read must come back as zero.
          if (!bus.m_wr_en) rdata_d = '0;
          if (bus.m_bytesel[0])      state_d = StSetupLo;
          else if (bus.m_bytesel[1]) state_d = StSetupHi;
          else                       state_d = StAck;
        end
      end
      StSetupLo: state_d = StAccessLo;
      StAccessLo: begin
        if (wait_done) begin
          if (!wr_q) rdata_d[7:0] = sram_rdata;
          state_d = sel_q[1] ? StSetupHi : StAck;
        end
      end
      StSetupHi: state_d = StAccessHi;
      StAccessHi: begin
        if (wait_done) begin
          if (!wr_q) rdata_d[15:8] = sram_rdata;
          state_d = StAck;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign sram_addr     = {addr_q, hi_lane};
  assign sram_wdata    = hi_lane ? wdata_q[15:8] : wdata_q[7:0];
  assign sram_ce_n     = !(in_setup || in_access);
  assign sram_oe_n     = !(in_access && !wr_q);
  assign sram_we_n     = !(in_access && wr_q);
  assign sram_data_oe  = wr_q && (in_setup || in_access);
  assign bus.m_data_in = rdata_q;
  assign bus.m_ack     = (state_q == StAck);

endmodule

// File: tb/tb_sram_byte_bridge.sv
// Directed bench for sram_byte_bridge: one instance with 2 wait states, one with none.
module tb_sram_byte_bridge;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_byte_bridge_if bus ();
  sram_byte_bridge_if bus0 ();

  logic [19:0] sram_addr, sram_addr0;
  logic [7:0]  sram_wdata, sram_wdata0, sram_rdata, sram_rdata0;
  logic        sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic        sram_data_oe0, sram_ce_n0, sram_oe_n0, sram_we_n0;

  // SRAM model: every even byte reads 0xCD, every odd byte 0xAB.
  assign sram_rdata  = sram_addr[0] ? 8'hAB : 8'hCD;
  assign sram_rdata0 = 8'h00;

  sram_byte_bridge #(.WAIT_STATES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_data_oe (sram_data_oe),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n)
  );

  sram_byte_bridge #(.WAIT_STATES(0)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus0),
    .sram_addr    (sram_addr0),
    .sram_wdata   (sram_wdata0),
    .sram_rdata   (sram_rdata0),
    .sram_data_oe (sram_data_oe0),
    .sram_ce_n    (sram_ce_n0),
    .sram_oe_n    (sram_oe_n0),
    .sram_we_n    (sram_we_n0)
  );

  // Pin activity monitors, sampled mid-cycle.
  int ce_lo = 0, oe_lo = 0, we_lo = 0, doe_hi = 0, ack_cnt = 0, we_lo0 = 0;
  logic oe_prev = 1'b1, we_prev = 1'b1, we_prev0 = 1'b1;
  logic [19:0] rd_addr_q[$];
  logic [19:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [19:0] wr_addr_q0[$];
  logic [7:0]  wr_data_q0[$];

  always @(negedge clk) begin
    if (!sram_ce_n) ce_lo <= ce_lo + 1;
    if (!sram_oe_n) oe_lo <= oe_lo + 1;
    if (!sram_we_n) we_lo <= we_lo + 1;
    if (sram_data_oe) doe_hi <= doe_hi + 1;
    if (bus.m_ack) ack_cnt <= ack_cnt + 1;
    if (!sram_oe_n && oe_prev) rd_addr_q.push_back(sram_addr);
    if (!sram_we_n && we_prev) begin
      wr_addr_q.push_back(sram_addr);
      wr_data_q.push_back(sram_wdata);
    end
    if (!sram_we_n0) we_lo0 <= we_lo0 + 1;
    if (!sram_we_n0 && we_prev0) begin
      wr_addr_q0.push_back(sram_addr0);
      wr_data_q0.push_back(sram_wdata0);
    end
    oe_prev  <= sram_oe_n;
    we_prev  <= sram_we_n;
    we_prev0 <= sram_we_n0;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Call at #1 after a posedge with the DUT idle; returns the ack latency in cycles and
  // leaves the DUT idle again.
  task automatic access(input logic [1:0] sel, input logic wr, input logic [19:1] addr,
                        input logic [15:0] wd, output int lat);
    bus.m_access   = 1'b1;
    bus.m_bytesel  = sel;
    bus.m_wr_en    = wr;
    bus.m_addr     = addr;
    bus.m_data_out = wd;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (i == 0) bus.m_access = 1'b0;
      if (bus.m_ack) break;
    end
    bus.m_access = 1'b0;
    @(posedge clk); #1;
  endtask

  int lat, b_ce, b_oe, b_we, b_doe, b_ack, b_rd, b_wr, b_we0, b_wr0, c, a1, a2;

  initial begin
    bus.m_access = 1'b0; bus.m_bytesel = 2'b00; bus.m_wr_en = 1'b0;
    bus.m_addr = '0; bus.m_data_out = '0;
    bus0.m_access = 1'b0; bus0.m_bytesel = 2'b00; bus0.m_wr_en = 1'b0;
    bus0.m_addr = '0; bus0.m_data_out = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ack", {31'd0, bus.m_ack}, 32'd0);
    check_eq("reset_rdata", {16'd0, bus.m_data_in}, 32'd0);
    check_eq("reset_addr", {12'd0, sram_addr}, 32'd0);
    check_eq("reset_wdata", {24'd0, sram_wdata}, 32'd0);
    check_eq("reset_pins", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 32'b1110);
    reset = 1'b0;
    @(posedge clk); #1;

    // 16-bit read, two wait states
    b_ce = ce_lo; b_oe = oe_lo; b_ack = ack_cnt; b_rd = rd_addr_q.size();
    access(2'b11, 1'b0, 19'h091A2, 16'h0000, lat);
    check_eq("rd16_latency", lat, 32'd9);
    check_eq("rd16_data", {16'd0, bus.m_data_in}, 32'hABCD);
    check_eq("rd16_oe_cycles", oe_lo - b_oe, 32'd6);
    check_eq("rd16_ce_cycles", ce_lo - b_ce, 32'd8);
    check_eq("rd16_ack_pulses", ack_cnt - b_ack, 32'd1);
    check_eq("rd16_phases", rd_addr_q.size() - b_rd, 32'd2);
    if (rd_addr_q.size() >= b_rd + 2) begin
      check_eq("rd16_addr_lo", {12'd0, rd_addr_q[b_rd]}, 32'h12344);
      check_eq("rd16_addr_hi", {12'd0, rd_addr_q[b_rd+1]}, 32'h12345);
    end

    // 8-bit write on the high lane
    b_we = we_lo; b_doe = doe_hi; b_oe = oe_lo; b_wr = wr_addr_q.size();
    access(2'b10, 1'b1, 19'h00400, 16'h5A00, lat);
    check_eq("wr8_latency", lat, 32'd5);
    check_eq("wr8_we_cycles", we_lo - b_we, 32'd3);
    check_eq("wr8_doe_cycles", doe_hi - b_doe, 32'd4);
    check_eq("wr8_oe_cycles", oe_lo - b_oe, 32'd0);
    check_eq("wr8_phases", wr_addr_q.size() - b_wr, 32'd1);
    if (wr_addr_q.size() > b_wr) begin
      check_eq("wr8_addr", {12'd0, wr_addr_q[b_wr]}, 32'h00801);
      check_eq("wr8_byte", {24'd0, wr_data_q[b_wr]}, 32'h5A);
    end
    check_eq("wr8_rdata_kept", {16'd0, bus.m_data_in}, 32'hABCD);

    // Empty byte select: ack only
    b_ce = ce_lo;
    access(2'b00, 1'b0, 19'h00123, 16'h0000, lat);
    check_eq("sel00_latency", lat, 32'd1);
    check_eq("sel00_ce_cycles", ce_lo - b_ce, 32'd0);
    check_eq("sel00_rdata", {16'd0, bus.m_data_in}, 32'h0000);

    // Zero wait states, 16-bit write on the second instance
    b_we0 = we_lo0; b_wr0 = wr_addr_q0.size();
    bus0.m_access = 1'b1; bus0.m_bytesel = 2'b11; bus0.m_wr_en = 1'b1;
    bus0.m_addr = 19'h00010; bus0.m_data_out = 16'hBEEF;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (i == 0) bus0.m_access = 1'b0;
      if (bus0.m_ack) break;
    end
    bus0.m_access = 1'b0;
    @(posedge clk); #1;
    check_eq("w0_latency", lat, 32'd5);
    check_eq("w0_we_cycles", we_lo0 - b_we0, 32'd2);
    check_eq("w0_phases", wr_addr_q0.size() - b_wr0, 32'd2);
    if (wr_addr_q0.size() >= b_wr0 + 2) begin
      check_eq("w0_byte_lo", {wr_addr_q0[b_wr0], wr_data_q0[b_wr0]}, 32'h00020EF);
      check_eq("w0_byte_hi", {wr_addr_q0[b_wr0+1], wr_data_q0[b_wr0+1]}, 32'h00021BE);
    end

    // Reset during the high-lane access of a read
    bus.m_access = 1'b1; bus.m_bytesel = 2'b11; bus.m_wr_en = 1'b0; bus.m_addr = 19'h00077;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 0) bus.m_access = 1'b0;
    end
    check_eq("rst_mid_in_hi", {30'd0, sram_oe_n, sram_addr[0]}, 32'b01);
    b_ack = ack_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_mid_pins", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 32'b1110);
    check_eq("rst_mid_ack", {31'd0, bus.m_ack}, 32'd0);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_eq("rst_mid_no_ack", ack_cnt - b_ack, 32'd0);
    check_eq("rst_mid_rdata", {16'd0, bus.m_data_in}, 32'd0);
    access(2'b11, 1'b0, 19'h00055, 16'h0000, lat);
    check_eq("rst_fresh_latency", lat, 32'd9);
    check_eq("rst_fresh_data", {16'd0, bus.m_data_in}, 32'hABCD);

    // m_access held across two low-lane reads; address changed mid-first-access
    b_rd = rd_addr_q.size();
    bus.m_access = 1'b1; bus.m_bytesel = 2'b01; bus.m_wr_en = 1'b0; bus.m_addr = 19'h01000;
    c = 0; a1 = 0; a2 = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      c++;
      if (c == 1) bus.m_addr = 19'h02000;
      if (bus.m_ack) begin
        if (a1 == 0) a1 = c;
        else begin
          a2 = c;
          break;
        end
      end
      if (a1 != 0 && c == a1 + 2) bus.m_access = 1'b0;
    end
    bus.m_access = 1'b0;
    @(posedge clk); #1;
    check_eq("b2b_first_latency", a1, 32'd5);
    check_eq("b2b_gap", a2 - a1, 32'd6);
    check_eq("b2b_phases", rd_addr_q.size() - b_rd, 32'd2);
    if (rd_addr_q.size() >= b_rd + 2) begin
      check_eq("b2b_addr_first", {12'd0, rd_addr_q[b_rd]}, 32'h02000);
      check_eq("b2b_addr_second", {12'd0, rd_addr_q[b_rd+1]}, 32'h04000);
    end
    check_eq("b2b_data", {16'd0, bus.m_data_in}, 32'h00CD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
